// File: rtl/mul_pkg.sv
// mul_pkg: shared types and legal-range constants for the sequential
// multiplier family (mul_approx_seq and its partial-product generator).
//   state_e    - controller states IDLE / RUN / DONE
//   WIDTH_MIN  - smallest legal operand width
//   WIDTH_MAX  - largest legal operand width
//   TRUNC_MIN  - smallest legal truncation column count
//   trunc_max  - largest legal truncation column count for a given width
//   idx_bits   - width of the iteration index for a given operand width
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int TRUNC_MIN = 0;

  function automatic int trunc_max(input int width);
    return 2 * width - 1;
  endfunction

  function automatic int idx_bits(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mul_pp_mask.sv
// mul_pp_mask: combinational generator of one partial product a<<i,
// zero-extended to 2*WIDTH, with columns below TRUNC forced to zero when
// approx is set. Produces zero when the selecting multiplier bit is 0.
// Ports:
//   a      in   WIDTH        multiplicand
//   b_bit  in   1            multiplier bit selecting this row
//   i      in   idx_bits     row index (shift amount)
//   approx in   1            1 = truncate low columns
//   pp     out  2*WIDTH      masked partial product
// Optional feature macro: MUL_APPROX_SEQ_APPROX_EN. When undefined the
// column mask is not built and approx is ignored.
module mul_pp_mask
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic [WIDTH-1:0]           a,
  input  logic                       b_bit,
  input  logic [idx_bits(WIDTH)-1:0] i,
  input  logic                       approx,
  output logic [2*WIDTH-1:0]         pp
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("mul_pp_mask: WIDTH out of range");
  end
  if (TRUNC < TRUNC_MIN || TRUNC > trunc_max(WIDTH)) begin : g_bad_trunc
    $error("mul_pp_mask: TRUNC out of range");
  end

`ifdef MUL_APPROX_SEQ_APPROX_EN
  // Ones above the truncated columns; TRUNC=0 keeps every column.
  localparam logic [2*WIDTH-1:0] KEEP_MASK = {(2*WIDTH){1'b1}} << TRUNC;
`else
  logic unused_approx;
  assign unused_approx = approx;
`endif

  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    shifted = {{WIDTH{1'b0}}, a} << i;
    pp      = b_bit ? shifted : '0;
`ifdef MUL_APPROX_SEQ_APPROX_EN
    if (approx) begin
      pp = pp & KEEP_MASK;
    end
`endif
  end

endmodule

// File: rtl/mul_approx_seq.sv
// mul_approx_seq: sequential unsigned shift-add multiplier, one partial
// product per cycle, with a per-operation approximate mode that drops the
// low TRUNC partial-product columns. Fixed latency WIDTH+1, no overlap.
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operands present
//   in_ready   out  1        block can accept operands (IDLE only)
//   in_a       in   WIDTH    multiplicand
//   in_b       in   WIDTH    multiplier
//   in_approx  in   1        1 = truncated mode for this operation
//   out_valid  out  1        result present
//   out_ready  in   1        consumer accepts the result
//   out_p      out  2*WIDTH  product, held until the next result loads
//   busy       out  1        high in RUN and DONE
// Optional feature macro: MUL_APPROX_SEQ_APPROX_EN. When undefined,
// in_approx is ignored and every operation is exact.
//
// state   | meaning
// --------+----------------------------------------------------
// ST_IDLE | waiting for operands, in_ready high
// ST_RUN  | adding partial product i, i = 0..WIDTH-1
// ST_DONE | out_valid high, out_p held until out_ready
module mul_approx_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("mul_approx_seq: WIDTH out of range");
  end
  if (TRUNC < TRUNC_MIN || TRUNC > trunc_max(WIDTH)) begin : g_bad_trunc
    $error("mul_approx_seq: TRUNC out of range");
  end

  localparam int IW = idx_bits(WIDTH);
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               approx_q, approx_d;
  logic [IW-1:0]      i_q, i_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_p_q, out_p_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] pp;
  logic               in_approx_eff;

`ifdef MUL_APPROX_SEQ_APPROX_EN
  assign in_approx_eff = in_approx;
`else
  logic unused_in_approx;
  assign unused_in_approx = in_approx;
  assign in_approx_eff    = 1'b0;
`endif

  mul_pp_mask #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_pp_mask (
    .a      (a_q),
    .b_bit  (b_q[i_q]),
    .i      (i_q),
    .approx (approx_q),
    .pp     (pp)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    i_d      = i_q;
    acc_d    = acc_q;
    out_p_d  = out_p_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          approx_d = in_approx_eff;
          i_d      = '0;
          acc_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + pp;
        i_d   = i_q + 1'b1;
        if (i_q == I_LAST) begin
          out_p_d = acc_q + pp;
          i_d     = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs registered from the next state so they line up with it.
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      approx_q    <= 1'b0;
      i_q         <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      approx_q    <= approx_d;
      i_q         <= i_d;
      acc_q       <= acc_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Gated by rst so the block never advertises readiness during reset.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;

endmodule
